// File: rtl/i281_exec_pkg.sv
// Shared types and defaults for the i281 execution controller.
// Latency: n/a; backpressure: n/a.
package i281_exec_pkg;

    localparam int PC_W_DEF        = 6;
    localparam int CNT_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } exec_state_e;

endpackage

// File: rtl/i281_exec_ctrl_sync_edge.sv
// Multi-flop synchronizer for a board-level async level, with a rising-edge pulse.
// Latency: SYNC_STAGES cycles to sync_o, rise_o combinational on it; backpressure: none.
module i281_sync_edge
    import i281_exec_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clock,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;

endmodule

// File: rtl/i281_exec_ctrl.sv
// i281 run/step/halt/breakpoint controller driving the datapath run enable; breakpoint under I281_BREAKPOINT_EN.
// Latency: run is combinational from registered state/flags/PC; backpressure: none (halt waits for instr_done).
module i281_exec_ctrl
    import i281_exec_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mode_run,
    input  logic             step_btn,
    input  logic             halt_req,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  current_pc,
    input  logic             instr_done,
    output logic             run,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       rst_sync_q;
    logic             rst_n;
    logic             mr_sync;
    logic             mr_rise_unused;
    logic             step_sync_unused;
    logic             step_pulse;
    logic             bp_hit;
    exec_state_e      state_q, state_d;
    logic             from_break_q, from_break_d;
    logic             first_q, first_d;
    logic             boundary_q, boundary_d;
    logic             enter_active;
    logic [CNT_W-1:0] instr_cnt_q, cycle_cnt_q;

    // Async assert, release aligned to clock so no flop sees a mid-cycle deassertion.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    i281_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mode (
        .clock   (clock),
        .rst_n   (rst_n),
        .async_i (mode_run),
        .sync_o  (mr_sync),
        .rise_o  (mr_rise_unused)
    );

    i281_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_step (
        .clock   (clock),
        .rst_n   (rst_n),
        .async_i (step_btn),
        .sync_o  (step_sync_unused),
        .rise_o  (step_pulse)
    );

`ifdef I281_BREAKPOINT_EN
    // first_q skips the check on the instruction we are just (re)starting from.
    assign bp_hit = bp_en && boundary_q && !first_q && (current_pc == bp_addr);
    assign halted = (state_q == ST_BREAK);
`else
    logic bp_unused;
    assign bp_unused = ^{bp_en, bp_addr, current_pc, first_q, boundary_q};
    assign bp_hit    = 1'b0;
    assign halted    = 1'b0;
`endif

    assign run   = ((state_q == ST_RUN) && !bp_hit) || (state_q == ST_STEP);
    assign state = state_q;

    always_comb begin
        state_d      = state_q;
        from_break_d = from_break_q;
        case (state_q)
            ST_IDLE: begin
                if (halt_req) begin
                    state_d = ST_IDLE;
                end else if (mr_sync) begin
                    state_d = ST_RUN;
                end else if (step_pulse) begin
                    state_d      = ST_STEP;
                    from_break_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (bp_hit) begin
                    state_d = ST_BREAK;
                end else if (instr_done && (halt_req || !mr_sync)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (instr_done) begin
                    state_d = from_break_q ? ST_BREAK : ST_IDLE;
                end
            end
            ST_BREAK: begin
                if (step_pulse && !halt_req) begin
                    state_d      = ST_STEP;
                    from_break_d = 1'b1;
                end else if (!mr_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        enter_active = (state_d != state_q) && ((state_d == ST_RUN) || (state_d == ST_STEP));
        first_d      = first_q;
        boundary_d   = boundary_q;
        if (enter_active) begin
            first_d    = 1'b1;
            boundary_d = 1'b1;
        end else if (run) begin
            first_d    = 1'b0;
            boundary_d = instr_done;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            from_break_q <= 1'b0;
            first_q      <= 1'b0;
            boundary_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            from_break_q <= from_break_d;
            first_q      <= first_d;
            boundary_q   <= boundary_d;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            if (run && instr_done && (instr_cnt_q != CNT_MAX)) begin
                instr_cnt_q <= instr_cnt_q + CNT_W'(1);
            end
            if (run && (cycle_cnt_q != CNT_MAX)) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
        end
    end

    assign instr_count = instr_cnt_q;
    assign cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_i281_exec_ctrl.sv
// Bench for i281_exec_ctrl: a small datapath stand-in plus a cycle-level reference model.
module tb_i281_exec_ctrl;

    localparam int PC_W  = 6;
    localparam int CNT_W = 16;
    localparam int S     = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             mode_run = 1'b0;
    logic             step_btn = 1'b0;
    logic             halt_req = 1'b0;
    logic             bp_en = 1'b0;
    logic [PC_W-1:0]  bp_addr = '0;
    logic [PC_W-1:0]  current_pc;
    logic             instr_done;
    logic             run;
    logic [1:0]       state;
    logic             halted;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] cycle_count;

    i281_exec_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .SYNC_STAGES(S)) dut (
        .clock       (clock),
        .reset       (reset),
        .mode_run    (mode_run),
        .step_btn    (step_btn),
        .halt_req    (halt_req),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .current_pc  (current_pc),
        .instr_done  (instr_done),
        .run         (run),
        .state       (state),
        .halted      (halted),
        .instr_count (instr_count),
        .cycle_count (cycle_count)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    endtask

    // Datapath stand-in: each PC holds an instruction of len[pc] cycles, advancing only while run.
    logic [PC_W-1:0] pc = '0;
    int              cyc = 0;
    int              len [64];
    int              pc_rst_seq = 0, pc_rst_seen = 0;
    bit              m_run_last = 1'b0;

    assign current_pc = pc;
    assign instr_done = (cyc == len[pc] - 1);

    always @(posedge clock) begin
        #1;
        if (pc_rst_seq != pc_rst_seen) begin
            pc_rst_seen = pc_rst_seq;
            pc  = '0;
            cyc = 0;
        end else if (m_run_last) begin
            if (cyc == len[pc] - 1) begin
                pc  = pc + 1'b1;
                cyc = 0;
            end else begin
                cyc++;
            end
        end
    end

    // Reference model: 0 idle, 1 run, 2 step, 3 break.
    int   m_st;
    bit   m_first, m_bound, m_from_break, m_run, m_hit, m_sync_mr, m_pulse;
    int   m_icnt, m_ccnt, m_nxt;
    bit   mr_h[$];
    bit   st_h[$];
    int   force_seq = 0, force_seen = 0;

    always @(negedge clock) begin
        if (!reset) begin
            m_st = 0; m_first = 0; m_bound = 0; m_from_break = 0;
            m_icnt = 0; m_ccnt = 0; m_run_last = 0;
            mr_h.delete(); st_h.delete();
            for (int i = 0; i <= S; i++) begin
                mr_h.push_back(1'b0);
                st_h.push_back(1'b0);
            end
        end else begin
            if (force_seq != force_seen) begin
                force_seen = force_seq;
                m_icnt = 'hFFFE;
            end
            m_sync_mr = mr_h[S-1];
            m_pulse   = st_h[S-1] && !st_h[S];
`ifdef I281_BREAKPOINT_EN
            m_hit = bp_en && m_bound && !m_first && (current_pc == bp_addr);
`else
            m_hit = 1'b0;
`endif
            m_run = (m_st == 1 && !m_hit) || m_st == 2;

            check("run", run, m_run);
            check("state", state, m_st);
            check("halted", halted, m_st == 3);
            check("instr_count", instr_count, m_icnt);
            check("cycle_count", cycle_count, m_ccnt);

            m_nxt = m_st;
            case (m_st)
                0: if (!halt_req) begin
                       if (m_sync_mr) m_nxt = 1;
                       else if (m_pulse) begin m_nxt = 2; m_from_break = 0; end
                   end
                1: if (m_hit) m_nxt = 3;
                   else if (instr_done && (halt_req || !m_sync_mr)) m_nxt = 0;
                2: if (instr_done) m_nxt = m_from_break ? 3 : 0;
                default: if (m_pulse && !halt_req) begin m_nxt = 2; m_from_break = 1; end
                         else if (!m_sync_mr) m_nxt = 0;
            endcase
            if (m_nxt != m_st && (m_nxt == 1 || m_nxt == 2)) begin
                m_first = 1; m_bound = 1;
            end else if (m_run) begin
                m_first = 0; m_bound = instr_done;
            end
            if (m_run && instr_done && m_icnt < 'hFFFF) m_icnt++;
            if (m_run && m_ccnt < 'hFFFF) m_ccnt++;
            m_st = m_nxt;
            m_run_last = m_run;
            mr_h.push_front(mode_run); void'(mr_h.pop_back());
            st_h.push_front(step_btn); void'(st_h.pop_back());
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic wait_state(input int s, input int lim, input string nm);
        int k = 0;
        while (state !== 2'(s) && k < lim) begin
            tick(1);
            k++;
        end
        check(nm, state, s);
    endtask

    task automatic wait_mid(input string nm);
        int k = 0;
        while (!(run === 1'b1 && cyc == 1) && k < 40) begin
            tick(1);
            k++;
        end
        check(nm, (k < 40), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int runs, first_k;
        for (int i = 0; i < 64; i++) len[i] = 1;

        // Reset
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(4);
        check("rst_state", state, 0);
        check("rst_run", run, 0);
        check("rst_halted", halted, 0);
        check("rst_icnt", instr_count, 0);
        check("rst_ccnt", cycle_count, 0);

        // Free run: RUN after S+1 cycles, three single-cycle instructions, then halt
        mode_run = 1'b1;
        tick(S);
        check("t1_still_idle", state, 0);
        tick(1);
        check("t1_run_entry", state, 1);
        tick(2);
        halt_req = 1'b1;
        mode_run = 1'b0;
        tick(1);
        check("t1_idle", state, 0);
        check("t1_icnt", instr_count, 3);
        check("t1_ccnt", cycle_count, 3);
        tick(S + 2);
        halt_req = 1'b0;
        tick(2);

        // Single step over a 3-cycle instruction
        len[pc] = 3;
        step_btn = 1'b1;
        tick(1);
        step_btn = 1'b0;
        runs = 0;
        first_k = -1;
        for (int k = 0; k < 12; k++) begin
            if (run === 1'b1) begin
                runs++;
                if (first_k < 0) first_k = k;
            end
            tick(1);
        end
        check("t2_step_latency", first_k, S);
        check("t2_run_cycles", runs, 3);
        check("t2_icnt", instr_count, 4);
        check("t2_idle", state, 0);

`ifdef I281_BREAKPOINT_EN
        // Breakpoint at PC 5, then step over it
        pc_rst_seq++;
        for (int i = 0; i < 64; i++) len[i] = (i % 3) + 1;
        tick(1);
        bp_en = 1'b1;
        bp_addr = 6'd5;
        mode_run = 1'b1;
        wait_state(3, 80, "t3_break");
        check("t3_pc", current_pc, 5);
        check("t3_run", run, 0);
        check("t3_halted", halted, 1);
        step_btn = 1'b1;
        tick(1);
        step_btn = 1'b0;
        wait_state(2, 10, "t3_step_enter");
        wait_state(3, 10, "t3_step_back");
        check("t3_pc_after", current_pc, 6);
        mode_run = 1'b0;
        wait_state(0, 10, "t3_idle");
        bp_en = 1'b0;
        tick(2);
`endif

        // Halt in the 2nd cycle of a 3-cycle instruction
        for (int i = 0; i < 64; i++) len[i] = 3;
        mode_run = 1'b1;
        wait_mid("t4_reach_mid");
        halt_req = 1'b1;
        check("t4_run_mid", run, 1);
        tick(1);
        check("t4_run_last", run, 1);
        check("t4_done_last", instr_done, 1);
        tick(1);
        check("t4_idle", state, 0);
        tick(8);
        check("t4_no_restart", state, 0);
        check("t4_no_run", run, 0);
        mode_run = 1'b0;
        tick(S + 2);
        halt_req = 1'b0;
        tick(2);

        // Counter saturation
        for (int i = 0; i < 64; i++) len[i] = 1;
        force dut.instr_cnt_q = 16'hFFFE;
        force_seq++;
        #1;
        release dut.instr_cnt_q;
        mode_run = 1'b1;
        tick(S + 6);
        check("t5_sat", instr_count, 16'hFFFF);
        mode_run = 1'b0;
        wait_state(0, 20, "t5_idle");

        // Random phase
        for (int i = 0; i < 64; i++) len[i] = $urandom_range(1, 3);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) mode_run = ~mode_run;
            if ($urandom_range(0, 7) == 0) step_btn = ~step_btn;
            halt_req = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 49) == 0) bp_en = ~bp_en;
            if ($urandom_range(0, 99) == 0) bp_addr = PC_W'($urandom_range(0, 63));
            tick(1);
        end

        // Async reset mid multicycle instruction
        halt_req = 1'b0; bp_en = 1'b0; step_btn = 1'b0; mode_run = 1'b0;
        tick(20);
        for (int i = 0; i < 64; i++) len[i] = 3;
        mode_run = 1'b1;
        wait_mid("t6_reach_mid");
        #1;
        reset = 1'b0;
        #1;
        check("t6_run_drop", run, 0);
        check("t6_state", state, 0);
        check("t6_halted", halted, 0);
        check("t6_icnt", instr_count, 0);
        check("t6_ccnt", cycle_count, 0);
        mode_run = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(5);
        mode_run = 1'b1;
        tick(12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
